// File: rtl/hmm_pkg.sv
// Shared constants, FSM encoding and saturating score arithmetic
// for the HMM Viterbi frame sequencer.
package hmm_pkg;
  localparam int DIM   = 12;
  localparam int STATE = 12;
  localparam int SW    = 64;

  localparam logic signed [SW-1:0] NEG_INF =
    {1'b1, {(SW-1){1'b0}}};
  localparam logic signed [SW-1:0] SCORE_MAX =
    {1'b0, {(SW-1){1'b1}}};

  localparam logic signed [SW-1:0] A_STAY [STATE] =
    '{default: SW'(-5)};
  localparam logic signed [SW-1:0] A_NEXT [STATE] =
    '{default: SW'(-1)};

  localparam logic [3:0] J_LAST   = 4'(STATE - 1);
  localparam logic [3:0] DIM_LAST = 4'(DIM - 1);
  localparam logic [3:0] DIM_N    = 4'(DIM);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FILL   = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_FLUSH  = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;

  // NEG_INF is absorbing; finite sums clamp instead of wrapping
  function automatic logic signed [SW-1:0] sat_add(
    input logic signed [SW-1:0] a,
    input logic signed [SW-1:0] b
  );
    logic signed [SW:0] s;
    s = {a[SW-1], a} + {b[SW-1], b};
    if (a == NEG_INF || b == NEG_INF)
      sat_add = NEG_INF;
    else if (s > $signed({1'b0, SCORE_MAX}))
      sat_add = SCORE_MAX;
    else if (s < $signed({1'b1, NEG_INF + SW'(1)}))
      sat_add = NEG_INF + SW'(1);
    else
      sat_add = s[SW-1:0];
  endfunction
endpackage

// File: rtl/viterbi_acs.sv
// Combinational add-compare-select for one left-to-right
// Viterbi state update.
module viterbi_acs
  import hmm_pkg::*;
(
  input  logic signed [SW-1:0] cur_i,
  input  logic signed [SW-1:0] prev_i,
  input  logic signed [SW-1:0] stay_i,
  input  logic signed [SW-1:0] next_i,
  input  logic signed [SW-1:0] b_i,
  input  logic                 first_i,
  input  logic                 zero_i,
  output logic signed [SW-1:0] delta_o
);
  logic signed [SW-1:0] stay;
  logic signed [SW-1:0] adv;
  logic signed [SW-1:0] pick;

  always_comb begin
    stay = sat_add(cur_i, stay_i);
    adv  = zero_i ? NEG_INF : sat_add(prev_i, next_i);
    pick = (adv > stay) ? adv : stay;
    if (first_i)
      delta_o = zero_i ? b_i : NEG_INF;
    else
      delta_o = sat_add(pick, b_i);
  end
endmodule

// File: rtl/hmm_viterbi_sequencer.sv
// Frame controller: buffers features, drives the Gaussian scorer
// and runs an in-place Viterbi recursion with running argmax.
module hmm_viterbi_sequencer
  import hmm_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 feat_valid,
  input  logic signed [31:0]   feat_data,
  input  logic                 feat_last,
  output logic                 feat_ready,
  output logic                 hmm_start,
  output logic [31:0]          hmm_x,
  input  logic                 hmm_load,
  input  logic                 hmm_dv,
  input  logic [15:0]          hmm_index,
  input  logic signed [SW-1:0] hmm_score,
  input  logic                 hmm_done,
  output logic                 best_valid,
  output logic [3:0]           best_state,
  output logic signed [SW-1:0] best_score,
  output logic                 best_last,
  output logic [15:0]          frame_cnt,
  output logic                 busy,
  output logic                 err
);
  logic [2:0]           st_q, st_d;
  logic [3:0]           cnt_q;
  logic [3:0]           j_q;
  logic [31:0]          buf_q [DIM];
  logic signed [SW-1:0] delta_q [STATE];
  logic signed [SW-1:0] prev_q;
  logic signed [SW-1:0] max_q;
  logic [3:0]           arg_q;
  logic                 last_f_q;
  logic                 first_q;
  logic                 err_q;
  logic                 bv_q;
  logic [3:0]           bs_q;
  logic signed [SW-1:0] bsc_q;
  logic                 bl_q;
  logic [15:0]          fc_q;
  logic [3:0]           jidx, jm1, xi;
  logic signed [SW-1:0] acs_d;
  logic                 unused_load;

  assign unused_load = hmm_load;

  assign jidx = (j_q <= J_LAST) ? j_q : 4'd0;
  assign jm1  = (jidx == 4'd0) ? 4'd0 : jidx - 4'd1;
  assign xi   = (cnt_q < DIM_N) ? cnt_q : 4'd0;

  assign feat_ready = (st_q == S_FILL);
  assign hmm_start  = (st_q == S_RUN);
  assign busy       = (st_q != S_IDLE);
  assign hmm_x      = (hmm_start && cnt_q < DIM_N)
                    ? buf_q[xi] : 32'd0;
  assign best_valid = bv_q;
  assign best_state = bs_q;
  assign best_score = bsc_q;
  assign best_last  = bl_q;
  assign frame_cnt  = fc_q;
  assign err        = err_q;

  viterbi_acs u_acs (
    .cur_i   (delta_q[jidx]),
    .prev_i  (prev_q),
    .stay_i  (A_STAY[jidx]),
    .next_i  (A_NEXT[jm1]),
    .b_i     (hmm_score),
    .first_i (first_q),
    .zero_i  (jidx == 4'd0),
    .delta_o (acs_d)
  );

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      S_IDLE:   if (feat_valid) st_d = S_FILL;
      S_FILL:   if (feat_valid && cnt_q == DIM_LAST)
                  st_d = S_RUN;
      S_RUN:    if (hmm_done) st_d = S_FLUSH;
      S_FLUSH:  st_d = S_REPORT;
      S_REPORT: st_d = feat_valid ? S_FILL : S_IDLE;
      default:  st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q     <= S_IDLE;
      cnt_q    <= '0;
      j_q      <= '0;
      prev_q   <= '0;
      max_q    <= NEG_INF;
      arg_q    <= '0;
      last_f_q <= 1'b0;
      first_q  <= 1'b1;
      err_q    <= 1'b0;
      bv_q     <= 1'b0;
      bs_q     <= '0;
      bsc_q    <= '0;
      bl_q     <= 1'b0;
      fc_q     <= '0;
      for (int i = 0; i < DIM; i++) buf_q[i] <= '0;
      for (int i = 0; i < STATE; i++) delta_q[i] <= NEG_INF;
    end else begin
      st_q <= st_d;
      bv_q <= 1'b0;
      unique case (st_q)
        S_FILL: if (feat_valid) begin
          buf_q[cnt_q] <= feat_data;
          last_f_q     <= last_f_q | feat_last;
          cnt_q <= (cnt_q == DIM_LAST) ? 4'd0 : cnt_q + 4'd1;
        end
        S_RUN: begin
          if (cnt_q != DIM_N) cnt_q <= cnt_q + 4'd1;
          if (hmm_dv) begin
            if (j_q <= J_LAST) begin
              delta_q[jidx] <= acs_d;
              prev_q        <= delta_q[jidx];
              j_q           <= j_q + 4'd1;
              if (j_q == 4'd0 || acs_d > max_q) begin
                max_q <= acs_d;
                arg_q <= j_q;
              end
              if (hmm_index != {12'd0, j_q}) err_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
          if (hmm_done) cnt_q <= '0;
        end
        S_FLUSH: begin
          bv_q  <= 1'b1;
          bs_q  <= arg_q;
          bsc_q <= max_q;
          bl_q  <= last_f_q;
          fc_q  <= fc_q + 16'd1;
          j_q   <= '0;
        end
        S_REPORT: begin
          bl_q     <= 1'b0;
          last_f_q <= 1'b0;
          first_q  <= last_f_q;
          // utterance ends: restart the recursion for the next one
          if (last_f_q) begin
            fc_q <= '0;
            for (int i = 0; i < STATE; i++)
              delta_q[i] <= NEG_INF;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_hmm_viterbi_sequencer.sv
// Directed and randomized frames against a behavioural scorer
// and an array-based Viterbi reference model.
module tb_hmm_viterbi_sequencer;
  localparam logic signed [63:0] NINF = 64'h8000_0000_0000_0000;
  localparam logic signed [63:0] SMAX = 64'h7FFF_FFFF_FFFF_FFFF;

  logic        clk = 0;
  logic        reset = 1;
  logic        feat_valid = 0;
  logic signed [31:0] feat_data = 0;
  logic        feat_last = 0;
  logic        feat_ready, hmm_start;
  logic [31:0] hmm_x;
  logic        hmm_load = 0;
  logic        hmm_dv = 0;
  logic [15:0] hmm_index = 0;
  logic signed [63:0] hmm_score = 0;
  logic        hmm_done = 0;
  logic        best_valid, best_last, busy, err;
  logic [3:0]  best_state;
  logic signed [63:0] best_score;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  logic signed [63:0] md [12];
  logic signed [63:0] bv [12];
  logic [31:0] fv [12];
  bit m_first = 1;
  int m_fcnt = 0;
  bit m_err = 0;

  always #5 clk = ~clk;

  hmm_viterbi_sequencer dut (
    .clk(clk), .reset(reset),
    .feat_valid(feat_valid), .feat_data(feat_data),
    .feat_last(feat_last), .feat_ready(feat_ready),
    .hmm_start(hmm_start), .hmm_x(hmm_x),
    .hmm_load(hmm_load), .hmm_dv(hmm_dv),
    .hmm_index(hmm_index), .hmm_score(hmm_score),
    .hmm_done(hmm_done), .best_valid(best_valid),
    .best_state(best_state), .best_score(best_score),
    .best_last(best_last), .frame_cnt(frame_cnt),
    .busy(busy), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] m_add(
    input logic signed [63:0] a, input logic signed [63:0] b);
    logic signed [65:0] s;
    if (a == NINF || b == NINF) return NINF;
    s = 66'(a) + 66'(b);
    if (s > 66'(SMAX)) return SMAX;
    if (s <= 66'(NINF)) return NINF + 64'sd1;
    return s[63:0];
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 12; j++) md[j] = NINF;
    m_first = 1;
    m_fcnt = 0;
  endtask

  function automatic logic signed [63:0] pre_b(input int j);
    logic signed [63:0] stay, adv;
    stay = m_add(md[j], -64'sd5);
    adv  = (j == 0) ? NINF : m_add(md[j-1], -64'sd1);
    return (adv > stay) ? adv : stay;
  endfunction

  task automatic model_frame(output logic [3:0] st,
                             output logic signed [63:0] sc);
    logic signed [63:0] nd [12];
    for (int j = 0; j < 12; j++)
      nd[j] = m_first ? ((j == 0) ? bv[0] : NINF)
                      : m_add(pre_b(j), bv[j]);
    md = nd;
    st = 0;
    sc = md[0];
    for (int j = 1; j < 12; j++)
      if (md[j] > sc) begin sc = md[j]; st = 4'(j); end
    m_first = 0;
    m_fcnt++;
  endtask

  task automatic do_reset();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    m_err = 0;
  endtask

  task automatic run_frame(input bit last, input int bad_j,
                           input int abort_j, input int extra);
    int k, g;
    bit ok;
    logic [3:0] es;
    logic signed [63:0] esc;
    for (int i = 0; i < 12; i++) fv[i] = $urandom;
    k = 0; g = 0;
    feat_valid = 1;
    while (k < 12 && g < 200) begin
      @(negedge clk);
      feat_data = fv[k];
      feat_last = last && (k == 7);
      if (feat_ready) k++;
      g++;
    end
    @(posedge clk); #1;
    feat_valid = 0; feat_last = 0;
    chk("feed_words", 64'(k), 64'd12);
    g = 0;
    @(negedge clk);
    while (!hmm_start && g < 50) begin @(negedge clk); g++; end
    chk("start_high", 64'(hmm_start), 64'd1);
    ok = 1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      if (hmm_x !== fv[c]) ok = 0;
    end
    @(negedge clk);
    if (hmm_x !== 32'd0) ok = 0;
    chk("hmm_x_seq", 64'(ok), 64'd1);
    for (int j = 0; j < 12 + extra; j++) begin
      @(posedge clk); #1;
      hmm_dv = 1;
      hmm_index = 16'((j == bad_j) ? 3 : j);
      hmm_score = (j < 12) ? bv[j] : 64'sd77;
      if (j == abort_j) reset = 1;
      @(posedge clk); #1;
      hmm_dv = 0;
      if (j == abort_j) begin
        reset = 0;
        @(negedge clk);
        chk("abort_start", 64'(hmm_start), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_score", best_score, 64'd0);
        chk("abort_fcnt", 64'(frame_cnt), 64'd0);
        chk("abort_err", 64'(err), 64'd0);
        model_reset();
        m_err = 0;
        return;
      end
    end
    if ((bad_j >= 0 && bad_j < 12) || extra > 0) m_err = 1;
    @(posedge clk); #1 hmm_done = 1;
    @(posedge clk); #1 hmm_done = 0;
    @(negedge clk);
    chk("flush_start", 64'(hmm_start), 64'd0);
    model_frame(es, esc);
    g = 0;
    while (!best_valid && g < 10) begin @(negedge clk); g++; end
    chk("best_valid", 64'(best_valid), 64'd1);
    chk("best_state", 64'(best_state), 64'(es));
    chk("best_score", best_score, esc);
    chk("best_last", 64'(best_last), 64'(last));
    chk("frame_cnt", 64'(frame_cnt), 64'(m_fcnt));
    chk("err", 64'(err), 64'(m_err));
    @(negedge clk);
    chk("valid_pulse", 64'(best_valid), 64'd0);
    if (last) model_reset();
    chk("fcnt_after", 64'(frame_cnt), 64'(m_fcnt));
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(feat_ready), 64'd0);
    chk("rst_start", 64'(hmm_start), 64'd0);
    chk("rst_valid", 64'(best_valid), 64'd0);
    chk("rst_fcnt", 64'(frame_cnt), 64'd0);
    chk("rst_err", 64'(err), 64'd0);

    for (int j = 0; j < 12; j++) bv[j] = -64'sd10 * 64'(j);
    run_frame(1, -1, -1, 0);
    chk("t1_state", 64'(best_state), 64'd0);
    chk("t1_score", best_score, 64'd0);

    run_frame(0, -1, -1, 0);
    for (int j = 0; j < 12; j++) bv[j] = -64'sd100;
    bv[0] = 0; bv[1] = -64'sd2;
    run_frame(1, -1, -1, 0);
    chk("t2_state", 64'(best_state), 64'd1);
    chk("t2_score", best_score, -64'sd3);

    for (int j = 0; j < 12; j++) bv[j] = 0;
    for (int f = 0; f < 6; f++) run_frame(0, -1, -1, 0);
    for (int j = 0; j < 12; j++)
      bv[j] = (j == 2 || j == 5) ? 64'sd100 - pre_b(j)
                                 : -64'sd1000;
    run_frame(1, -1, -1, 0);
    chk("tie_state", 64'(best_state), 64'd2);
    chk("tie_score", best_score, 64'sd100);

    for (int j = 0; j < 12; j++) bv[j] = SMAX;
    run_frame(0, -1, -1, 0);
    run_frame(1, -1, -1, 0);
    chk("clamp_score", best_score, SMAX);
    chk("clamp_state", 64'(best_state), 64'd0);

    for (int j = 0; j < 12; j++)
      bv[j] = 64'sd0 - 64'($urandom_range(60, 0));
    run_frame(0, 2, -1, 0);
    run_frame(1, -1, -1, 0);
    chk("err_sticky", 64'(err), 64'd1);
    do_reset();
    @(negedge clk);
    chk("err_cleared", 64'(err), 64'd0);

    run_frame(1, -1, -1, 1);
    do_reset();

    run_frame(0, -1, -1, 0);
    run_frame(0, -1, 5, 0);
    run_frame(1, -1, -1, 0);

    for (int u = 0; u < 4; u++) begin
      int n;
      n = $urandom_range(4, 1);
      for (int f = 0; f < n; f++) begin
        for (int j = 0; j < 12; j++)
          bv[j] = 64'sd0 - 64'($urandom_range(60, 0));
        run_frame(f == n - 1, -1, -1, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
